// File: rtl/nes_pkg.sv
// nes_pkg: shared button indices, frame width and responder state type
package nes_pkg;
  localparam int NES_BITS = 8;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/nes_edge_sync.sv
// nes_edge_sync: multi-flop synchronizer with registered rise/fall pulses
module nes_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev;
  assign level = sync_q[SYNC_STAGES-1];
  // synchronize the host pin, then register one-cycle edge pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev <= level;
      rise <= level & ~prev;
      fall <= ~level & prev;
    end
  end
endmodule

// File: rtl/nes_controller_responder.sv
// nes_controller_responder: pad-side NES serial responder driven by host latch/clock
module nes_controller_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nesLatch,
  input  logic                nesClock,
  input  logic [NES_BITS-1:0] buttons,
  output logic                nesData,
  output logic                pollStrobe,
  output logic [3:0]          shiftCount
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic latch_level, latch_rise, latch_fall;
  logic clock_level, clock_rise, clock_fall;
  state_t state, state_nx;
  logic [NES_BITS-1:0] shreg, shreg_nx;
  logic [3:0] count_nx;
  logic [TW-1:0] timer, timer_nx;
  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk(clk), .reset(reset), .async_in(nesLatch),
    .level(latch_level), .rise(latch_rise), .fall(latch_fall)
  );
  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clock_sync (
    .clk(clk), .reset(reset), .async_in(nesClock),
    .level(clock_level), .rise(clock_rise), .fall(clock_fall)
  );
  // shreg is a flop, so the inverted LSB is already a registered output
  assign nesData = ~shreg[BTN_A];
  // state, shift register, bit counter and inactivity timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      shiftCount <= '0;
      timer <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      shiftCount <= count_nx;
      timer <= timer_nx;
    end
  end
  // next state: a high latch wins over everything, then per-state behaviour
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    count_nx = shiftCount;
    timer_nx = '0;
    pollStrobe = 1'b0;
    if (latch_level) begin
      state_nx = LOAD;
      shreg_nx = buttons;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          shreg_nx = '0;
          count_nx = '0;
        end
        LOAD: begin
          if (latch_fall) begin
            state_nx = SHIFT;
            pollStrobe = 1'b1;
          end else begin
            shreg_nx = buttons;
          end
        end
        SHIFT: begin
          if (clock_rise) begin
            shreg_nx = {1'b0, shreg[NES_BITS-1:1]};
            count_nx = shiftCount + 4'd1;
            state_nx = (shiftCount == 4'd7) ? DONE : SHIFT;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            shreg_nx = '0;
            count_nx = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        default: shreg_nx = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_nes_controller_responder.sv
// tb_nes_controller_responder: scoreboard bench for the NES pad responder
module tb_nes_controller_responder;
  localparam int TIMEOUT = 50000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic nesLatch = 1'b0;
  logic nesClock = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic nesData, pollStrobe;
  logic [3:0] shiftCount;
  int checks = 0;
  int errors = 0;
  int strobes = 0;
  bit exp_q[$];

  nes_controller_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset_n), .nesLatch(nesLatch), .nesClock(nesClock),
    .buttons(buttons), .nesData(nesData), .pollStrobe(pollStrobe), .shiftCount(shiftCount)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (pollStrobe === 1'b1) strobes <= strobes + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_expected(input logic [7:0] b);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(~b[i]);
  endtask

  task automatic poll(input logic [7:0] b, input int hi);
    buttons = b;
    push_expected(b);
    nesLatch = 1'b1;
    tick(hi);
    nesLatch = 1'b0;
    tick(6);
  endtask

  task automatic shift_bits(input int n, input int half, input string tag);
    bit e;
    for (int k = 0; k < n; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      checks++;
      if (nesData !== e) begin
        errors++;
        $display("FAIL %s bit%0d nesData=%b expected=%b", tag, k, nesData, e);
      end
      nesClock = 1'b1;
      tick(half);
      nesClock = 1'b0;
      tick(half);
    end
  endtask

  task automatic check_count(input logic [3:0] e, input string tag);
    checks++;
    if (shiftCount !== e) begin
      errors++;
      $display("FAIL %s shiftCount=%0d expected=%0d", tag, shiftCount, e);
    end
  endtask

  task automatic check_data(input logic e, input string tag);
    checks++;
    if (nesData !== e) begin
      errors++;
      $display("FAIL %s nesData=%b expected=%b", tag, nesData, e);
    end
  endtask

  task automatic check_strobes(input int e, input string tag);
    checks++;
    if (strobes !== e) begin
      errors++;
      $display("FAIL %s strobes=%0d expected=%0d", tag, strobes, e);
    end
  endtask

  task automatic test_reset();
    tick(3);
    check_data(1'b1, "reset_data");
    check_count(4'd0, "reset_count");
    checks++;
    if (pollStrobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe pollStrobe=%b expected=0", pollStrobe);
    end
    reset_n = 1'b1;
    tick(30);
    check_data(1'b1, "idle_data");
    check_count(4'd0, "idle_count");
    check_strobes(0, "idle_strobes");
  endtask

  task automatic test_basic();
    int s0;
    s0 = strobes;
    poll(8'b0000_0101, 600);
    shift_bits(8, 300, "basic");
    check_count(4'd8, "basic_count");
    check_data(1'b1, "basic_done_data");
    check_strobes(s0 + 1, "basic_strobes");
  endtask

  task automatic test_saturate();
    poll(8'hFF, 20);
    shift_bits(10, 8, "saturate");
    check_count(4'd8, "saturate_count");
  endtask

  task automatic test_sample_window();
    poll(8'h01, 20);
    buttons = 8'h80;
    shift_bits(8, 8, "window");
    check_count(4'd8, "window_count");
  endtask

  task automatic test_abort();
    poll(8'h5A, 20);
    shift_bits(3, 8, "pre_abort");
    check_count(4'd3, "pre_abort_count");
    buttons = 8'h10;
    nesLatch = 1'b1;
    tick(10);
    check_count(4'd0, "abort_load_count");
    check_data(1'b1, "abort_load_data");
    push_expected(8'h10);
    nesLatch = 1'b0;
    tick(6);
    shift_bits(8, 8, "abort");
    check_count(4'd8, "abort_count");
  endtask

  task automatic test_timeout();
    poll(8'h04, 20);
    shift_bits(2, 8, "pre_timeout");
    check_count(4'd2, "pre_timeout_count");
    check_data(1'b0, "pre_timeout_data");
    tick(TIMEOUT + 20);
    check_data(1'b1, "timeout_data");
    check_count(4'd0, "timeout_count");
  endtask

  task automatic test_reset_mid_shift();
    poll(8'h07, 20);
    shift_bits(2, 8, "pre_reset");
    check_data(1'b0, "pre_reset_data");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_data(1'b1, "async_reset_data");
    check_count(4'd0, "async_reset_count");
    tick(2);
    reset_n = 1'b1;
    tick(10);
    nesClock = 1'b1;
    tick(8);
    nesClock = 1'b0;
    tick(8);
    check_count(4'd0, "post_reset_count");
    check_data(1'b1, "post_reset_data");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_sample_window();
    test_abort();
    test_timeout();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nes_controller_responder.md
# nes_controller_responder

Board-side emulation of an NES gamepad: the responder end of the NES serial protocol whose host end drives nesLatch/nesClock and samples nesData. It captures eight active-high button inputs on the host's latch pulse and shifts them out active-low, one per host clock rising edge, in standard NES order. It lets the Capman host controller interface, and the CPU IO path behind it, be exercised on a second board or in loopback without a physical pad.

## Interface
- SYNC_STAGES, 2: flops in each nesLatch/nesClock synchronizer (min 2)
- TIMEOUT_CYCLES, 50000: clk cycles with no host clock edge in SHIFT before returning to IDLE (1 ms @ 50 MHz)
- clk  input  1  onboard 50 MHz clock
- reset  input  1  asynchronous, active-low reset
- nesLatch  input  1  host latch, asynchronous to clk, active-high
- nesClock  input  1  host shift clock, asynchronous to clk, shift on rising edge
- buttons  input  8  pressed = 1; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- nesData  output  1  serial button bit to host, active-low (0 = pressed)
- pollStrobe  output  1  one-cycle pulse on each synchronized latch falling edge
- shiftCount  output  4  bits shifted since last latch, 0..8, saturating

## Operation
- nesLatch and nesClock each pass through a SYNC_STAGES flop synchronizer, then a rise/fall edge detector.
- 8-bit shift register shreg; nesData = ~shreg[0], registered.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: shreg = 0, nesData = 1, shiftCount = 0. Sync latch high -> LOAD.
- LOAD: shreg <= buttons every cycle (transparent parallel load, as a 4021); shiftCount = 0; clock edges ignored. Sync latch falling edge -> SHIFT, pollStrobe = 1 for that cycle, shreg holds last loaded value.
- SHIFT: on sync clock rising edge: shreg <= {1'b0, shreg[7:1]}, shiftCount++. When shiftCount reaches 8 -> DONE. No clock edge for TIMEOUT_CYCLES -> IDLE.
- DONE: shreg = 0 so nesData = 1 (extra reads return "released"); further clock edges ignored; shiftCount stays 8.
- Sync latch high in any state -> LOAD (latch has absolute priority; a new poll aborts any shift in progress).
- Latch falling edge and clock rising edge in the same cycle: latch edge taken, clock edge dropped.
- Timeout counter clears on every clock rising edge and on entering SHIFT; counts only in SHIFT; width $clog2(TIMEOUT_CYCLES+1).
- buttons sampled only in LOAD; changes outside LOAD have no effect on the current poll.

## Timing
- Reset values: nesData = 1, pollStrobe = 0, shiftCount = 0, state IDLE, shreg = 0, timeout counter 0.
- Host-pin edge to internal edge pulse: SYNC_STAGES + 1 clk cycles; nesData updates 1 cycle later (SYNC_STAGES + 2 total, 4 cycles = 80 ns at default).
- Host must hold latch high ≥ SYNC_STAGES + 2 clk cycles and clock high/low ≥ SYNC_STAGES + 1 cycles each; standard 12 µs latch / 6 µs clock phases satisfy this with large margin.
- After latch falls, nesData = ~buttons[0] (A) is valid before the first host clock rising edge; bit n valid SYNC_STAGES + 2 cycles after the n-th rising edge.
- Reset assertion mid-poll: all outputs return to reset values immediately (async); after release, ignores pulses until next sync latch high.

## Structure
- Shared package nes_pkg: button index localparams (BTN_A..BTN_RIGHT), NES_BITS = 8, state enum type.
- Sub-module nes_edge_sync (parameter SYNC_STAGES; ports clk, reset, async in, outputs level, rise, fall), instantiated for nesLatch and nesClock.

## Test plan
- Reset released, no host activity -> nesData = 1, shiftCount = 0, pollStrobe never pulses.
- buttons = 8'b0000_0101 (A, Select), latch 12 µs, 8 clocks of 6 µs -> nesData sequence before each edge 0,1,0,1,1,1,1,1; pollStrobe one pulse; shiftCount ends 8.
- 10 clocks after one latch, buttons = 8'hFF -> first 8 bits 0, bits 9–10 read 1, shiftCount saturates at 8.
- buttons change from 8'h01 to 8'h80 after latch falls -> shifted data reflects 8'h01 only.
- Latch re-asserted after 3 shifts with buttons = 8'h10 -> state LOAD, shiftCount 0, then Up appears at bit 4 of the new poll.
- Latch then 2 clocks, then silence > 50000 cycles -> IDLE, nesData = 1; reset asserted mid-shift -> nesData = 1 asynchronously.
